seq_detect_ctrl: RTL
====================

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 The block SHALL have no parameters: pattern width is fixed at 8 bits and count width at 8 bits.
REQ-002 The block SHALL have port `clk`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port `reset_n`: input, 1 bit, asynchronous, active-low reset.
REQ-004 The block SHALL have port `cfg_we`: input, 1 bit, configuration write strobe.
REQ-005 The block SHALL have port `cfg_pattern`: input, 8 bits, target pattern; bit 0 is the most recently received bit.
REQ-006 The block SHALL have port `cfg_len`: input, 3 bits, pattern length minus 1 (1..8 bits).
REQ-007 The block SHALL have port `cfg_overlap`: input, 1 bit, 1 = overlapping detection, 0 = non-overlapping.
REQ-008 The block SHALL have port `cfg_target`: input, 8 bits, number of matches that ends a run.
REQ-009 The block SHALL have port `start`: input, 1 bit, begins a run (single-cycle pulse).
REQ-010 The block SHALL have port `abort`: input, 1 bit, terminates a run.
REQ-011 The block SHALL have port `x_valid`: input, 1 bit, qualifies `x`.
REQ-012 The block SHALL have port `x`: input, 1 bit, serial data bit.
REQ-013 The block SHALL have port `busy`: output, 1 bit, high in RUN.
REQ-014 The block SHALL have port `match`: output, 1 bit, one-cycle pulse per detection.
REQ-015 The block SHALL have port `match_count`: output, 8 bits, detections in the current or last run.
REQ-016 The block SHALL have port `done`: output, 1 bit, high in DONE.
REQ-017 The block SHALL have port `cfg_err`: output, 1 bit, one-cycle pulse on a rejected configuration write or a rejected `start`.

Function
REQ-018 The block SHALL implement FSM states IDLE, RUN and DONE; `busy` = (state==RUN) and `done` = (state==DONE).
REQ-019 On `cfg_we` in IDLE or DONE, the block SHALL latch pattern, len, overlap and target into shadow registers; the run uses only the shadow values.
REQ-020 On `cfg_we` in RUN, the block SHALL leave the shadow registers unchanged and pulse `cfg_err` on the next cycle.
REQ-021 On `start` in IDLE or DONE with shadow target != 0, the block SHALL go to RUN and, on the same edge, clear the history register (8 bits), the history count (0..8) and `match_count`.
REQ-022 On `start` with shadow target == 0, the block SHALL stay in its current state and pulse `cfg_err`.
REQ-023 The block SHALL ignore `start` while in RUN.
REQ-024 In RUN with `x_valid`=1, the block SHALL update on the edge: hist <= {hist[6:0], x}; hcnt <= min(hcnt+1, 8).
REQ-025 In RUN with `x_valid`=0, the block SHALL leave hist and hcnt unchanged and hold `match` low.
REQ-026 The match condition SHALL be computed on the new (post-shift) history: new_hcnt >= len+1 AND (new_hist & mask) == (pattern & mask), where mask = (1 << (len+1)) - 1 using 9-bit arithmetic so that len=7 gives 0xFF.
REQ-027 On a match, `match` SHALL be high for exactly the one cycle after the edge that sampled the completing bit (registered output, latency 1).
REQ-028 On a match, `match_count` SHALL increment on that same edge.
REQ-029 After a match with overlap=0, the block SHALL set hcnt to 0 on that edge, so no bit is reused.
REQ-030 After a match with overlap=1, the block SHALL keep hcnt as updated.
REQ-031 When a match makes `match_count` equal to target, the block SHALL go to DONE on the same edge; `match` still pulses.
REQ-032 The block SHALL ignore `x` in IDLE and DONE.
REQ-033 In DONE, the block SHALL hold `match_count` and `done` until `start` or reset.
REQ-034 Because `match_count` reaches target first, it SHALL never wrap.
REQ-035 On `abort` in RUN, the block SHALL go to IDLE, suppress any match on that edge and preserve `match_count`.
REQ-036 If `abort` and a match-qualifying bit arrive together, `abort` SHALL win.
REQ-037 `abort` in IDLE or DONE SHALL have no effect.

Reset
REQ-038 While `reset_n` is low, the block SHALL be in IDLE with all outputs 0, hist=0, hcnt=0 and `match_count`=0.
REQ-039 Reset SHALL initialise the shadow configuration to pattern=0x05, len=2, overlap=1, target=1 (detects "101").
REQ-040 Reset asserted mid-run SHALL take effect immediately; no `match` or `done` SHALL be produced after deassertion until a new `start`.

Verification
REQ-041 Overlap, len=2, pattern=0x05, target=8; start; x stream 1,0,1,0,1 -> `match` pulses after the 3rd and 5th bits; `match_count`=2; `busy`=1.
REQ-042 Same stream with overlap=0 -> a single `match` after the 3rd bit; `match_count`=1.
REQ-043 target=2, overlap=1, stream 1,0,1,0,1 -> `done`=1 and `busy`=0 the cycle after the 5th bit; `match_count`=2; later `x` ignored.
REQ-044 Stream 1,0,1 with `x_valid`=0 gaps of 3 cycles between bits -> exactly one `match` after the 3rd valid bit.
REQ-045 `cfg_we` during RUN -> `cfg_err` pulse and old pattern still used; `start` with target=0 -> `cfg_err`, state unchanged.
REQ-046 len=7, pattern=0xA5, stream 1,0,1,0,0,1,0,1 -> `match`; then `reset_n` pulse mid-run -> all outputs 0 and shadow pattern=0x05.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - serial bit-pattern detector with run control and match counting
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   cfg_we       configuration write strobe (accepted in IDLE/DONE only)
//   cfg_pattern  target pattern, bit 0 = most recently received bit
//   cfg_len      pattern length minus 1 (1..8 bits)
//   cfg_overlap  1 = overlapping detection, 0 = non-overlapping
//   cfg_target   number of matches that ends a run
//   start        begins a run (pulse)
//   abort        terminates a run
//   x_valid      qualifies x
//   x            serial data bit
//   busy         high while running
//   match        one-cycle pulse per detection
//   match_count  detections in the current or last run
//   done         high once the target count has been reached
//   cfg_err      one-cycle pulse on a rejected configuration write or start

module seq_detect_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cfg_we,
    input  logic [7:0] cfg_pattern,
    input  logic [2:0] cfg_len,
    input  logic       cfg_overlap,
    input  logic [7:0] cfg_target,
    input  logic       start,
    input  logic       abort,
    input  logic       x_valid,
    input  logic       x,
    output logic       busy,
    output logic       match,
    output logic [7:0] match_count,
    output logic       done,
    output logic       cfg_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;

    // Shadow configuration: a run only ever looks at these copies.
    logic [7:0] sh_pattern;
    logic [2:0] sh_len;
    logic       sh_overlap;
    logic [7:0] sh_target;

    logic [7:0] hist;
    logic [3:0] hcnt;

    logic [7:0] new_hist;
    logic [3:0] new_hcnt;
    logic [3:0] len_p1;
    logic [7:0] mask;
    logic [7:0] count_inc;
    logic       hit;

    // Match is judged on the history as it will be after this bit shifts in.
    // The mask keeps the low len+1 bits; shifting 0xFF right by 7-len gives
    // the same result as (1 << (len+1)) - 1 without a ninth bit.
    always_comb begin
        new_hist  = {hist[6:0], x};
        new_hcnt  = (hcnt >= 4'd8) ? 4'd8 : hcnt + 4'd1;
        len_p1    = {1'b0, sh_len} + 4'd1;
        mask      = 8'hFF >> (3'd7 - sh_len);
        count_inc = match_count + 8'd1;
        hit       = (new_hcnt >= len_p1) && ((new_hist & mask) == (sh_pattern & mask));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            sh_pattern  <= 8'h05;
            sh_len      <= 3'd2;
            sh_overlap  <= 1'b1;
            sh_target   <= 8'd1;
            hist        <= 8'h00;
            hcnt        <= 4'd0;
            match_count <= 8'd0;
            match       <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            match   <= 1'b0;
            cfg_err <= 1'b0;

            if (cfg_we) begin
                if (state == RUN) begin
                    cfg_err <= 1'b1;
                end else begin
                    sh_pattern <= cfg_pattern;
                    sh_len     <= cfg_len;
                    sh_overlap <= cfg_overlap;
                    sh_target  <= cfg_target;
                end
            end

            case (state)
                IDLE, DONE: begin
                    // start sees the shadow values from before any same-cycle write
                    if (start) begin
                        if (sh_target != 8'd0) begin
                            state       <= RUN;
                            hist        <= 8'h00;
                            hcnt        <= 4'd0;
                            match_count <= 8'd0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        // abort wins over any bit arriving on the same edge
                        state <= IDLE;
                    end else if (x_valid) begin
                        hist <= new_hist;
                        if (hit) begin
                            match       <= 1'b1;
                            match_count <= count_inc;
                            hcnt        <= sh_overlap ? new_hcnt : 4'd0;
                            if (count_inc == sh_target) begin
                                state <= DONE;
                            end
                        end else begin
                            hcnt <= new_hcnt;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
